// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for an ECC FIFO: reset sequencing, 2-entry skid buffer, ECC error counters.
// Optional FIFO_RD_CTRL_ECC_HALT_EN: a double-bit error stops reads until err_clr or flush.
module fifo_rd_ctrl #(
  parameter int DATA_W       = 16,
  parameter int CNT_W        = 16,
  parameter int RST_HOLD_CYC = 8,
  parameter int RST_WAIT_CYC = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              err_clr,
  output logic              fifo_rst,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  input  logic              fifo_sbiterr,
  input  logic              fifo_dbiterr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  sbe_cnt,
  output logic [CNT_W-1:0]  dbe_cnt,
  output logic              dbe_flag,
  output logic              busy
);

  localparam int TMR_MAX = (RST_HOLD_CYC > RST_WAIT_CYC) ? RST_HOLD_CYC : RST_WAIT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(RST_HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(RST_WAIT_CYC - 1);

  typedef enum logic [1:0] {
    S_RESET_HOLD = 2'd0,
    S_RESET_WAIT = 2'd1,
`ifdef FIFO_RD_CTRL_ECC_HALT_EN
    S_RUN        = 2'd2,
    S_HALT       = 2'd3
`else
    S_RUN        = 2'd2
`endif
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) sat_inc = v + CNT_W'(1);
    else                             sat_inc = v;
  endfunction

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               inflight_q, inflight_d;
  logic [1:0]         occ_q, occ_d;
  logic [DATA_W-1:0]  buf0_q, buf0_d, buf1_q, buf1_d;
  logic [CNT_W-1:0]   sbe_cnt_q, sbe_cnt_d, dbe_cnt_q, dbe_cnt_d;
  logic               dbe_flag_q, dbe_flag_d;

  logic       sample, push, pop, sbe_evt, dbe_evt;
  logic [2:0] lvl;

  // A word in flight during flush is discarded, never counted or pushed.
  assign sample  = inflight_q && !flush;
  assign dbe_evt = sample && fifo_dbiterr;
  assign sbe_evt = sample && !fifo_dbiterr && fifo_sbiterr;
  assign push    = sample && !fifo_dbiterr;
  assign pop     = (occ_q != 2'd0) && m_ready;
  assign lvl     = 3'(occ_q) + 3'(inflight_q) - 3'(pop);

`ifdef FIFO_RD_CTRL_ECC_HALT_EN
  // Suppress the read in the cycle the bad word arrives so nothing follows it.
  assign fifo_rd_en = (state_q == S_RUN) && !flush && !fifo_empty && (lvl < 3'd2) && !dbe_evt;
`else
  assign fifo_rd_en = (state_q == S_RUN) && !flush && !fifo_empty && (lvl < 3'd2);
`endif

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      S_RESET_HOLD: begin
        if (tmr_q == HOLD_LAST) begin
          state_d = S_RESET_WAIT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_RESET_WAIT: begin
        if (tmr_q == WAIT_LAST) begin
          state_d = S_RUN;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_RUN: begin
`ifdef FIFO_RD_CTRL_ECC_HALT_EN
        if (dbe_evt) state_d = S_HALT;
`endif
      end
`ifdef FIFO_RD_CTRL_ECC_HALT_EN
      S_HALT: begin
        if (err_clr) state_d = S_RUN;
      end
`endif
      default: state_d = S_RESET_HOLD;
    endcase
    if (flush) begin
      state_d = S_RESET_HOLD;
      tmr_d   = '0;
    end
  end

  always_comb begin
    occ_d      = occ_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    inflight_d = fifo_rd_en;
    // Clear is applied before the new event so a coincident error still counts once.
    sbe_cnt_d  = sat_inc(err_clr ? '0 : sbe_cnt_q, sbe_evt);
    dbe_cnt_d  = sat_inc(err_clr ? '0 : dbe_cnt_q, dbe_evt);
    dbe_flag_d = (err_clr ? 1'b0 : dbe_flag_q) | dbe_evt;
    if (flush) begin
      occ_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) buf0_d = fifo_dout;
          else               buf1_d = fifo_dout;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          buf0_d = buf1_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            buf0_d = fifo_dout;
          end else begin
            buf0_d = buf1_q;
            buf1_d = fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RESET_HOLD;
      tmr_q      <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      buf0_q     <= '0;
      sbe_cnt_q  <= '0;
      dbe_cnt_q  <= '0;
      dbe_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      sbe_cnt_q  <= sbe_cnt_d;
      dbe_cnt_q  <= dbe_cnt_d;
      dbe_flag_q <= dbe_flag_d;
    end
  end

  always_ff @(posedge clk) begin
    buf1_q <= buf1_d;
  end

  assign fifo_rst = (state_q == S_RESET_HOLD);
  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = buf0_q;
  assign sbe_cnt  = sbe_cnt_q;
  assign dbe_cnt  = dbe_cnt_q;
  assign dbe_flag = dbe_flag_q;
  assign busy     = (state_q != S_RUN);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: FIFO memory model plus an ordered-word and error-count reference.
module tb_fifo_rd_ctrl;
  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int HOLD = 8;
  localparam int WAIT = 32;
  localparam int CMAX = 65535;

  logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0, err_clr = 1'b0;
  logic          fifo_rst, fifo_rd_en, fifo_empty;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_sbiterr = 1'b0, fifo_dbiterr = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid, m_ready = 1'b0;
  logic [CW-1:0] sbe_cnt, dbe_cnt;
  logic          dbe_flag, busy;

  fifo_rd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .err_clr(err_clr),
    .fifo_rst(fifo_rst), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .fifo_sbiterr(fifo_sbiterr), .fifo_dbiterr(fifo_dbiterr),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt), .dbe_flag(dbe_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO model: words {sbiterr, dbiterr, data}; read data appears the cycle after rd_en.
  logic [DW+1:0] mem [0:131071];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_rst) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      {fifo_sbiterr, fifo_dbiterr, fifo_dout} <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int exp_sbe, exp_dbe, stall_bad, rdy_mode;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int tests_run = 0, tests_failed = 0;

  function automatic int sat_cnt(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic push_word(input logic [DW-1:0] d, input logic s, input logic b);
    mem[wr_ptr] = {s, b, d};
    wr_ptr++;
    if (b) exp_dbe++;
    else begin
      exp_q.push_back(d);
      if (s) exp_sbe++;
    end
  endtask

  task automatic reset_sb();
    exp_q.delete(); got_q.delete();
    exp_sbe = 0; exp_dbe = 0; stall_bad = 0; prev_stall = 1'b0;
  endtask

  // Advance one cycle, pick m_ready, log accepted words and any change while stalled.
  task automatic cycle();
    @(negedge clk);
    case (rdy_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) stall_bad++;
    if (m_valid === 1'b1 && m_ready) got_q.push_back(m_data);
    prev_stall = (m_valid === 1'b1) && !m_ready;
    prev_data  = m_data;
  endtask

  task automatic test_reset();
    int n_hold = 0, n_wait = 0, bad_rd = 0, g = 0;
    rst_n = 1'b0; rdy_mode = 0;
    repeat (3) cycle();
    tests_run++; if (fifo_rst !== 1'b1) begin tests_failed++; $display("FAIL rst_fifo_rst got=%b exp=1", fifo_rst); end
    tests_run++; if (fifo_rd_en !== 1'b0) begin tests_failed++; $display("FAIL rst_rd_en got=%b exp=0", fifo_rd_en); end
    tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
    tests_run++; if (m_data !== '0) begin tests_failed++; $display("FAIL rst_m_data got=%h exp=0", m_data); end
    tests_run++; if (sbe_cnt !== '0 || dbe_cnt !== '0) begin tests_failed++; $display("FAIL rst_cnt got=%h/%h exp=0/0", sbe_cnt, dbe_cnt); end
    tests_run++; if (dbe_flag !== 1'b0) begin tests_failed++; $display("FAIL rst_dbe_flag got=%b exp=0", dbe_flag); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rst_busy got=%b exp=1", busy); end
    rst_n = 1'b1;
    while (fifo_rst === 1'b1 && g < 200) begin
      n_hold++; if (fifo_rd_en !== 1'b0) bad_rd++; cycle(); g++;
    end
    while (fifo_rst === 1'b0 && busy === 1'b1 && g < 200) begin
      n_wait++; if (fifo_rd_en !== 1'b0) bad_rd++; cycle(); g++;
    end
    tests_run++; if (n_hold !== HOLD) begin tests_failed++; $display("FAIL hold_cycles got=%0d exp=%0d", n_hold, HOLD); end
    tests_run++; if (n_wait !== WAIT) begin tests_failed++; $display("FAIL wait_cycles got=%0d exp=%0d", n_wait, WAIT); end
    tests_run++; if (bad_rd !== 0) begin tests_failed++; $display("FAIL rd_before_run got=%0d exp=0", bad_rd); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL busy_after_seq got=%b exp=0", busy); end
  endtask

  task automatic test_stream();
    int gaps = 0, first_rd = -1, first_v = -1, n;
    reset_sb(); rdy_mode = 1;
    for (int i = 1; i <= 256; i++) push_word(DW'(i), 1'b0, 1'b0);
    #1;
    if (fifo_rd_en === 1'b1) first_rd = 0;
    for (int k = 1; k < 700 && got_q.size() < 256; k++) begin
      cycle();
      if (first_rd < 0 && fifo_rd_en === 1'b1) first_rd = k;
      if (first_v < 0 && m_valid === 1'b1) first_v = k;
      if (got_q.size() > 0 && got_q.size() < 256 && m_valid !== 1'b1) gaps++;
    end
    tests_run++; if (first_v - first_rd !== 2) begin tests_failed++; $display("FAIL first_latency got=%0d exp=2", first_v - first_rd); end
    tests_run++; if (gaps !== 0) begin tests_failed++; $display("FAIL stream_gaps got=%0d exp=0", gaps); end
    tests_run++; if (got_q.size() !== 256) begin tests_failed++; $display("FAIL stream_count got=%0d exp=256", got_q.size()); end
    n = (got_q.size() < 256) ? got_q.size() : 256;
    for (int i = 0; i < n; i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL stream_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    reset_sb(); rdy_mode = 2;
    for (int i = 0; i < 16; i++) push_word(DW'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0);
    for (int k = 0; k < 400 && got_q.size() < 16; k++) cycle();
    repeat (10) cycle();
    tests_run++; if (got_q.size() !== 16) begin tests_failed++; $display("FAIL bp_count got=%0d exp=16", got_q.size()); end
    tests_run++; if (stall_bad !== 0) begin tests_failed++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_bad); end
    tests_run++; if (int'(sbe_cnt) !== sat_cnt(exp_sbe)) begin tests_failed++; $display("FAIL bp_sbe_cnt got=%0d exp=%0d", sbe_cnt, sat_cnt(exp_sbe)); end
    n = (got_q.size() < 16) ? got_q.size() : 16;
    for (int i = 0; i < n; i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL bp_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_ecc();
    int n;
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    reset_sb(); rdy_mode = 1;
    for (int i = 1; i <= 8; i++) push_word(DW'(16'h0C00 + i), 1'(i == 3), 1'(i == 5));
    repeat (40) cycle();
    tests_run++; if (int'(sbe_cnt) !== exp_sbe) begin tests_failed++; $display("FAIL ecc_sbe_cnt got=%0d exp=%0d", sbe_cnt, exp_sbe); end
    tests_run++; if (int'(dbe_cnt) !== exp_dbe) begin tests_failed++; $display("FAIL ecc_dbe_cnt got=%0d exp=%0d", dbe_cnt, exp_dbe); end
    tests_run++; if (dbe_flag !== 1'b1) begin tests_failed++; $display("FAIL ecc_dbe_flag got=%b exp=1", dbe_flag); end
`ifdef FIFO_RD_CTRL_ECC_HALT_EN
    tests_run++; if (got_q.size() !== 4) begin tests_failed++; $display("FAIL halt_count got=%0d exp=4", got_q.size()); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL halt_busy got=%b exp=1", busy); end
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    repeat (40) cycle();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL halt_resume_busy got=%b exp=0", busy); end
`endif
    tests_run++; if (got_q.size() !== 7) begin tests_failed++; $display("FAIL ecc_count got=%0d exp=7", got_q.size()); end
    n = (got_q.size() < 7) ? got_q.size() : 7;
    for (int i = 0; i < n; i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL ecc_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_flush();
    int n_hold = 0, g = 0, n;
    reset_sb(); rdy_mode = 0;
    push_word(16'hB001, 1'b1, 1'b0);
    for (int i = 2; i <= 6; i++) push_word(DW'(16'hB000 + i), 1'b0, 1'b0);
    repeat (20) cycle();
    tests_run++; if (m_valid !== 1'b1 || sbe_cnt === '0) begin tests_failed++; $display("FAIL flush_precond got=%b/%0d exp=1/nonzero", m_valid, sbe_cnt); end
    got_q.delete(); exp_q.delete(); prev_stall = 1'b0; rdy_mode = 1;
    flush = 1'b1; err_clr = 1'b1;
    cycle();
    flush = 1'b0; err_clr = 1'b0;
    tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_m_valid got=%b exp=0", m_valid); end
    tests_run++; if (sbe_cnt !== '0 || dbe_cnt !== '0 || dbe_flag !== 1'b0) begin tests_failed++; $display("FAIL flush_clr got=%0d/%0d/%b exp=0/0/0", sbe_cnt, dbe_cnt, dbe_flag); end
    while (fifo_rst === 1'b1 && g < 200) begin n_hold++; cycle(); g++; end
    tests_run++; if (n_hold !== HOLD) begin tests_failed++; $display("FAIL flush_hold got=%0d exp=%0d", n_hold, HOLD); end
    while (busy === 1'b1 && g < 200) begin cycle(); g++; end
    tests_run++; if (got_q.size() !== 0) begin tests_failed++; $display("FAIL flush_stale got=%0d exp=0", got_q.size()); end
    for (int i = 1; i <= 4; i++) push_word(DW'(16'hF000 + i), 1'b0, 1'b0);
    repeat (30) cycle();
    tests_run++; if (got_q.size() !== 4) begin tests_failed++; $display("FAIL flush_after_count got=%0d exp=4", got_q.size()); end
    n = (got_q.size() < 4) ? got_q.size() : 4;
    for (int i = 0; i < n; i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL flush_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_saturation();
    localparam int NW = 65536 + 5;
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    reset_sb(); rdy_mode = 1;
    for (int i = 0; i < NW; i++) push_word(DW'(i), 1'b1, 1'b0);
    for (int k = 0; k < NW + 200 && got_q.size() < NW; k++) cycle();
    repeat (4) cycle();
    tests_run++; if (got_q.size() !== NW) begin tests_failed++; $display("FAIL sat_count got=%0d exp=%0d", got_q.size(), NW); end
    tests_run++; if (int'(sbe_cnt) !== sat_cnt(exp_sbe)) begin tests_failed++; $display("FAIL sat_sbe_cnt got=%0d exp=%0d", sbe_cnt, sat_cnt(exp_sbe)); end
    push_word(16'h5A5A, 1'b1, 1'b0);
    #1;
    tests_run++; if (fifo_rd_en !== 1'b1) begin tests_failed++; $display("FAIL sat_rd_en got=%b exp=1", fifo_rd_en); end
    cycle();
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    tests_run++; if (sbe_cnt !== CW'(1)) begin tests_failed++; $display("FAIL clr_with_sbe got=%0d exp=1", sbe_cnt); end
    push_word(16'hA5A5, 1'b0, 1'b1);
    #1;
    cycle();
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    tests_run++; if (dbe_cnt !== CW'(1) || dbe_flag !== 1'b1 || sbe_cnt !== '0) begin tests_failed++; $display("FAIL clr_with_dbe got=%0d/%b/%0d exp=1/1/0", dbe_cnt, dbe_flag, sbe_cnt); end
`ifdef FIFO_RD_CTRL_ECC_HALT_EN
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL clr_dbe_halt got=%b exp=1", busy); end
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_ecc();
    test_flush();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, FIFO word and output data width.
REQ-002 SHALL have parameter CNT_W, default 16, width of the ECC error counters.
REQ-003 SHALL have parameter RST_HOLD_CYC, default 8, number of cycles fifo_rst is held high.
REQ-004 SHALL have parameter RST_WAIT_CYC, default 32, number of post-reset cycles before the first read.
REQ-005 SHALL have the following ports, one per line:
- clk  in  1  single clock; FIFO read-side clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  one-cycle pulse that restarts the FIFO reset sequence.
- err_clr  in  1  one-cycle pulse that clears the counters, dbe_flag and HALT.
- fifo_rst  out  1  reset to the FIFO.
- fifo_rd_en  out  1  FIFO read enable.
- fifo_dout  in  DATA_W  FIFO read data, valid 1 cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_sbiterr  in  1  single-bit ECC error (corrected), aligned with fifo_dout.
- fifo_dbiterr  in  1  double-bit ECC error (uncorrectable), aligned with fifo_dout.
- m_data  out  DATA_W  output stream data.
- m_valid  out  1  output stream valid.
- m_ready  in  1  output stream ready.
- sbe_cnt  out  CNT_W  saturating count of single-bit errors.
- dbe_cnt  out  CNT_W  saturating count of double-bit errors.
- dbe_flag  out  1  sticky flag for a double-bit error.
- busy  out  1  high in every state except RUN.

Function
REQ-006 SHALL implement the states RESET_HOLD, RESET_WAIT, RUN and HALT.
REQ-007 RESET_HOLD: fifo_rst=1 for exactly RST_HOLD_CYC cycles, then go to RESET_WAIT.
REQ-008 RESET_WAIT: fifo_rst=0 and fifo_rd_en=0 for exactly RST_WAIT_CYC cycles, then go to RUN.
REQ-009 RUN: fifo_rd_en SHALL equal !fifo_empty && (occ + inflight - pop) < 2, where:
- occ is the 0..2 occupancy of the internal skid buffer;
- inflight is fifo_rd_en registered;
- pop is m_valid && m_ready.
REQ-010 fifo_rd_en SHALL be 0 in every state other than RUN.
REQ-011 One cycle after fifo_rd_en, the block SHALL sample fifo_dout, fifo_sbiterr and fifo_dbiterr.
REQ-012 A sampled word without dbiterr SHALL be pushed to the skid buffer; with sbiterr set it SHALL still be pushed and sbe_cnt incremented.
REQ-013 A sampled word with dbiterr SHALL NOT be pushed; dbe_cnt SHALL increment and dbe_flag SHALL set.
REQ-014 m_valid SHALL equal (occ != 0) and m_data SHALL show the oldest word; words SHALL leave in FIFO order.
REQ-015 While m_valid=1 and m_ready=0, m_data SHALL hold stable and no word SHALL be lost or duplicated.
REQ-016 With fifo_empty=0 and m_ready=1 continuously, the block SHALL sustain 1 word/cycle; first m_valid comes 2 cycles after the first fifo_rd_en.
REQ-017 Both counters SHALL saturate at 2^CNT_W-1.
REQ-018 flush in any state SHALL go to RESET_HOLD, restart the hold counter, clear occ and discard any in-flight word.
REQ-019 err_clr SHALL zero sbe_cnt, dbe_cnt and dbe_flag and move HALT to RUN.
REQ-020 If err_clr coincides with a sampled error, the clear SHALL apply first; the result is count=1 and dbe_flag=1 on a dbiterr.
REQ-021 If flush and err_clr coincide, flush SHALL take priority for the state and err_clr SHALL still clear the counters.

Reset
REQ-022 While rst_n=0, the outputs SHALL be: state RESET_HOLD, fifo_rst=1, fifo_rd_en=0, m_valid=0, m_data=0, counters=0, dbe_flag=0, busy=1.
REQ-023 After rst_n deasserts, the sequence of REQ-007/REQ-008 SHALL run before any read.

Configuration
REQ-024 With macro FIFO_RD_CTRL_ECC_HALT_EN defined, a sampled dbiterr in RUN SHALL move the state to HALT:
- fifo_rd_en=0 in HALT;
- words already in the skid buffer still drain;
- HALT is left only by err_clr or flush.
REQ-025 Without FIFO_RD_CTRL_ECC_HALT_EN, the dbiterr word SHALL be dropped and counted per REQ-013, and RUN SHALL continue with no HALT state logic.

Verification
REQ-026 Release rst_n -> fifo_rst=1 for 8 cycles, then 32 cycles of fifo_rd_en=0, then busy=0.
REQ-027 Preload 0x0001..0x0100 and hold m_ready=1 -> 256 words in order at 1 word/cycle, with no gaps after the first.
REQ-028 Preload 16 words and toggle m_ready randomly at 50% -> all 16 words arrive in order, m_data stable while stalled, none lost or duplicated.
REQ-029 Put sbiterr on word 3 and dbiterr on word 5 of 8 -> 7 words out (word 5 missing), sbe_cnt=1, dbe_cnt=1, dbe_flag=1; with ECC_HALT_EN, reads stop after word 5 until err_clr, then words 6..8 follow.
REQ-030 Pulse flush mid-stream with occ=2 -> m_valid=0 next cycle, fifo_rst=1 for 8 cycles, no stale word ever output.
REQ-031 Force 2^16+5 sbiterr words -> sbe_cnt=0xFFFF; err_clr together with a new sbiterr -> sbe_cnt=1.
